// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: shared definitions for the pipelined arithmetic blocks.
//   ADD_MODE / SUB_MODE : encoding of the 'sub' mode input
//   calc_nblk()         : number of BLK-bit carry-lookahead stages for a width
package pipe_add_pkg;

    localparam logic ADD_MODE = 1'b0;
    localparam logic SUB_MODE = 1'b1;

    // Pipeline depth of a block-CLA datapath: one stage per BLK-bit slice.
    function automatic int calc_nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/pipe_add_cla.sv
// cla_blk: purely combinational BLK-bit carry-lookahead adder slice.
//   a, b  : slice operands (b already inverted by the caller for subtract)
//   ci    : carry into bit 0 of the slice
//   s     : slice sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (used by the caller for signed overflow)
module cla_blk #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Flat lookahead: c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]ci,
    // built by walking down from bit i-1 while accumulating the propagate term.
    always_comb begin
        logic prop;
        c    = '0;
        prop = 1'b1;
        for (int i = 0; i <= BLK; i++) begin
            prop = 1'b1;
            c[i] = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & prop);
                prop = prop & p[j];
            end
            c[i] = c[i] | (ci & prop);
        end
    end

    assign s     = p ^ c[BLK-1:0];
    assign co    = c[BLK];
    assign c_msb = c[BLK-1];

endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined add/subtract unit, one BLK-bit CLA slice per stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = ~stall)
//   a, b, c_in, sub     : operands, carry-in (add only), mode (1 = a - b)
//   out_valid/out_ready : result handshake
//   sum, c_out, ovf     : result, carry-out (no-borrow on subtract), signed overflow
// Latency is NBLK = WIDTH/BLK cycles from acceptance to out_valid; the whole
// pipe freezes on one global enable while the output is stalled.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK   = calc_nblk(WIDTH, BLK);
    localparam int STAGES = NBLK - 1;

    if (BLK < 1 || WIDTH < BLK || (WIDTH % BLK) != 0) begin : g_bad_cfg
        $error("pipe_add: WIDTH=%0d must be a non-zero multiple of BLK=%0d", WIDTH, BLK);
    end

    // Operand preparation: subtract is a + ~b + 1, c_in ignored.
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

    assign b_eff  = (sub == SUB_MODE) ? ~b : b;
    assign ci_eff = (sub == ADD_MODE) ? c_in : 1'b1;

    // Handshake / global enable
    logic             stall;
    logic [STAGES:0]  vld_pipe;

    assign out_valid = vld_pipe[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k <= STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Stage registers. Operands are carried at full width; bits below the
    // current slice are dead once consumed and are trimmed by synthesis.
    logic [STAGES:0][WIDTH-1:0] a_q;
    logic [STAGES:0][WIDTH-1:0] b_q;
    logic [STAGES:0][WIDTH-1:0] s_q;
    logic [STAGES:0]            co_q;
    logic [STAGES:0]            ov_q;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic [WIDTH-1:0] s_nxt;
        logic [BLK-1:0]   s_blk;
        logic             co;
        logic             c_msb;

        if (k == 0) begin : g_src
            assign a_src = a;
            assign b_src = b_eff;
            assign s_src = '0;
            assign c_src = ci_eff;
        end else begin : g_src
            assign a_src = a_q[k-1];
            assign b_src = b_q[k-1];
            assign s_src = s_q[k-1];
            assign c_src = co_q[k-1];
        end

        cla_blk #(.BLK(BLK)) u_cla (
            .a     (a_src[k*BLK +: BLK]),
            .b     (b_src[k*BLK +: BLK]),
            .ci    (c_src),
            .s     (s_blk),
            .co    (co),
            .c_msb (c_msb)
        );

        always_comb begin
            s_nxt              = s_src;
            s_nxt[k*BLK +: BLK] = s_blk;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                co_q[k] <= 1'b0;
                ov_q[k] <= 1'b0;
            end else if (!stall) begin
                a_q[k]  <= a_src;
                b_q[k]  <= b_src;
                s_q[k]  <= s_nxt;
                co_q[k] <= co;
                // Only meaningful in the last stage, where c_msb is the
                // carry into bit WIDTH-1.
                ov_q[k] <= co ^ c_msb;
            end
        end
    end

    assign sum   = s_q[STAGES];
    assign c_out = co_q[STAGES];
    assign ovf   = ov_q[STAGES];

    // Last-stage operand copies and early-stage overflow bits have no reader.
    logic unused_tail;
    assign unused_tail = ^{a_q[STAGES], b_q[STAGES], ov_q};

endmodule

// File: tb/tb_pipe_add.sv
module tb_pipe_add;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t q16[$];
    exp_t q32[$];

    logic        v16 = 1'b0, ci16 = 1'b0, sb16 = 1'b0, ordy16 = 1'b0;
    logic        rdy16, ov16, co16, of16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    logic        v32 = 1'b0, ci32 = 1'b0, sb32 = 1'b0, ordy32 = 1'b0;
    logic        rdy32, ov32, co32, of32;
    logic [31:0] a32 = '0, b32 = '0, sum32;

    always #5 clk = ~clk;

    pipe_add #(.WIDTH(16), .BLK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
        .a(a16), .b(b16), .c_in(ci16), .sub(sb16),
        .out_valid(ov16), .out_ready(ordy16), .sum(sum16), .c_out(co16), .ovf(of16)
    );

    pipe_add #(.WIDTH(32), .BLK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .a(a32), .b(b32), .c_in(ci32), .sub(sb32),
        .out_valid(ov32), .out_ready(ordy32), .sum(sum32), .c_out(co32), .ovf(of32)
    );

    // Reference: wide integer add, sign-rule overflow.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb, input int w);
        exp_t        r;
        logic [32:0] full;
        logic [31:0] mask, xx, yy;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        xx     = x & mask;
        yy     = sb ? (~y & mask) : (y & mask);
        full   = {1'b0, xx} + {1'b0, yy} + {32'd0, (sb ? 1'b1 : ci)};
        r.s    = full[31:0] & mask;
        r.co   = full[w];
        r.ov   = (xx[w-1] == yy[w-1]) && (r.s[w-1] != xx[w-1]);
        return r;
    endfunction

    // Scoreboard: pop/compare retiring results, push on acceptance.
    always @(negedge clk) begin : sb
        exp_t e;
        if (rst_n) begin
            if (ov16 && ordy16) begin
                total++;
                if (q16.size() == 0) begin
                    bad++;
                    $display("FAIL sb16_extra: got sum=%h with nothing outstanding", sum16);
                end else begin
                    e = q16.pop_front();
                    if ({sum16, co16, of16} !== {e.s[15:0], e.co, e.ov}) begin
                        bad++;
                        $display("FAIL sb16_result: got sum=%h c_out=%b ovf=%b, want sum=%h c_out=%b ovf=%b",
                                 sum16, co16, of16, e.s[15:0], e.co, e.ov);
                    end
                end
            end
            if (ov32 && ordy32) begin
                total++;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL sb32_extra: got sum=%h with nothing outstanding", sum32);
                end else begin
                    e = q32.pop_front();
                    if ({sum32, co32, of32} !== {e.s, e.co, e.ov}) begin
                        bad++;
                        $display("FAIL sb32_result: got sum=%h c_out=%b ovf=%b, want sum=%h c_out=%b ovf=%b",
                                 sum32, co32, of32, e.s, e.co, e.ov);
                    end
                end
            end
            if (v16 && rdy16) q16.push_back(model({16'd0, a16}, {16'd0, b16}, ci16, sb16, 16));
            if (v32 && rdy32) q32.push_back(model(a32, b32, ci32, sb32, 32));
        end
    end

    // Present a beat at the current time, hold it until accepted, return #1 after the accepting edge.
    task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
        int n = 0;
        a16 = x; b16 = y; ci16 = ci; sb16 = s; v16 = 1'b1;
        do begin @(negedge clk); n++; end while (!rdy16 && n < 50);
        if (!rdy16) begin
            total++; bad++;
            $display("FAIL drive16_timeout: in_ready=%b after %0d cycles, want 1", rdy16, n);
        end
        @(posedge clk); #1;
        v16 = 1'b0;
    endtask

    task automatic drive32(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        int n = 0;
        a32 = x; b32 = y; ci32 = ci; sb32 = s; v32 = 1'b1;
        do begin @(negedge clk); n++; end while (!rdy32 && n < 50);
        if (!rdy32) begin
            total++; bad++;
            $display("FAIL drive32_timeout: in_ready=%b after %0d cycles, want 1", rdy32, n);
        end
        @(posedge clk); #1;
        v32 = 1'b0;
    endtask

    task automatic wait_out16();
        int n = 0;
        do begin @(negedge clk); n++; end while (!ov16 && n < 20);
        if (!ov16) begin
            total++; bad++;
            $display("FAIL wait_out16_timeout: out_valid=%b, want 1", ov16);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q32.size() != 0) && n < 100) begin @(negedge clk); n++; end
        total++;
        if (q16.size() != 0 || q32.size() != 0) begin
            bad++;
            $display("FAIL drain: outstanding16=%0d outstanding32=%0d, want 0 and 0", q16.size(), q32.size());
        end
    endtask

    task automatic test_reset();
        ordy16 = 1'b0; ordy32 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ov16, sum16, co16, of16} !== '0) begin
            bad++; $display("FAIL reset16_out: got valid=%b sum=%h c_out=%b ovf=%b, want all 0", ov16, sum16, co16, of16);
        end
        total++;
        if (rdy16 !== 1'b1) begin bad++; $display("FAIL reset16_ready: got %b want 1", rdy16); end
        total++;
        if ({ov32, sum32, co32, of32} !== '0) begin
            bad++; $display("FAIL reset32_out: got valid=%b sum=%h c_out=%b ovf=%b, want all 0", ov32, sum32, co32, of32);
        end
        total++;
        if (rdy32 !== 1'b1) begin bad++; $display("FAIL reset32_ready: got %b want 1", rdy32); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ordy16 = 1'b1; ordy32 = 1'b1;
    endtask

    // FFFF + 1 with exact latency: accepted at edge 1, visible after edge 4.
    task automatic test_basic();
        @(posedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; sb16 = 1'b0; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (i < 4) begin
                if (ov16 !== 1'b0) begin bad++; $display("FAIL basic_latency: out_valid=%b after edge %0d, want 0", ov16, i); end
                @(posedge clk);
            end else if ({ov16, sum16, co16, of16} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL basic_add: got valid=%b sum=%h c_out=%b ovf=%b, want 1 0000 1 0", ov16, sum16, co16, of16);
            end
        end
    endtask

    task automatic test_add_ovf();
        @(posedge clk); #1;
        drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_out16();
        total++;
        if ({sum16, co16, of16} !== {16'h8000, 1'b0, 1'b1}) begin
            bad++; $display("FAIL add_ovf: got sum=%h c_out=%b ovf=%b, want 8000 0 1", sum16, co16, of16);
        end
    endtask

    task automatic test_sub();
        @(posedge clk); #1;
        drive16(16'h8000, 16'h0001, 1'b0, 1'b1);
        drive16(16'h0003, 16'h0005, 1'b1, 1'b1);   // c_in must be ignored
        wait_out16();
        total++;
        if ({sum16, co16, of16} !== {16'h7FFF, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sub_ovf: got sum=%h c_out=%b ovf=%b, want 7fff 1 1", sum16, co16, of16);
        end
        @(negedge clk);
        total++;
        if ({ov16, sum16, co16, of16} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
            bad++; $display("FAIL sub_borrow: got valid=%b sum=%h c_out=%b ovf=%b, want 1 fffe 0 0", ov16, sum16, co16, of16);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 8; i++) drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            for (int j = 0; j < 8; j++) drive32($urandom, $urandom, 1'($urandom), 1'($urandom));
            begin
                int n = 0, run = 0;
                while (!ov16 && n < 20) begin @(negedge clk); n++; end
                while (ov16 && run < 9) begin run++; @(negedge clk); end
                total++;
                if (run != 8) begin bad++; $display("FAIL b2b16_stream: %0d consecutive results, want 8", run); end
            end
            begin
                int n = 0, run = 0;
                while (!ov32 && n < 20) begin @(negedge clk); n++; end
                while (ov32 && run < 9) begin run++; @(negedge clk); end
                total++;
                if (run != 8) begin bad++; $display("FAIL b2b32_stream: %0d consecutive results, want 8", run); end
            end
        join
        drain();
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 6; i++) drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            begin
                exp_t e;
                repeat (5) @(posedge clk);
                #1 ordy16 = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    total++;
                    if (q16.size() == 0) begin
                        bad++; $display("FAIL bp_hold: nothing outstanding during stall, want a held result");
                    end else begin
                        e = q16[0];
                        if ({rdy16, ov16, sum16, co16, of16} !== {1'b0, 1'b1, e.s[15:0], e.co, e.ov}) begin
                            bad++;
                            $display("FAIL bp_hold: cycle %0d got ready=%b valid=%b sum=%h c_out=%b ovf=%b, want 0 1 %h %b %b",
                                     c, rdy16, ov16, sum16, co16, of16, e.s[15:0], e.co, e.ov);
                        end
                    end
                    @(posedge clk); #1;
                end
                ordy16 = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        rst_n = 1'b0;
        q16.delete();
        #1;
        total++;
        if ({ov16, sum16, co16, of16} !== '0) begin
            bad++; $display("FAIL midreset_clear: got valid=%b sum=%h c_out=%b ovf=%b, want all 0", ov16, sum16, co16, of16);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (ov16 !== 1'b0) begin bad++; $display("FAIL midreset_stale: out_valid=%b at idle cycle %0d, want 0", ov16, c); end
        end
        @(posedge clk); #1;
        a16 = 16'h1234; b16 = 16'h0FF0; ci16 = 1'b1; sb16 = 1'b0; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (ov16 !== (i == 4)) begin bad++; $display("FAIL midreset_latency: out_valid=%b after edge %0d, want %b", ov16, i, (i == 4)); end
            if (i < 4) @(posedge clk);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_add_ovf();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
